// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand driver: default widths, ALU op codes and FSM states.
package alu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OPW   = 3;

    localparam logic [OPW-1:0] ALU_AND = 3'd0;
    localparam logic [OPW-1:0] ALU_OR  = 3'd1;
    localparam logic [OPW-1:0] ALU_ADD = 3'd2;
    localparam logic [OPW-1:0] ALU_SUB = 3'd3;
    localparam logic [OPW-1:0] ALU_SLT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } drv_state_t;

endpackage

// File: rtl/alu_operand_driver_if.sv
// Request/result handshake bundle for alu_operand_driver.
// res_zero exists only when ALU_DRV_ZERO_FLAG_EN is defined.
interface alu_operand_driver_if #(
    parameter int unsigned WIDTH = alu_pkg::WIDTH,
    parameter int unsigned OPW   = alu_pkg::OPW
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [OPW-1:0]   req_op;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
`ifdef ALU_DRV_ZERO_FLAG_EN
    logic             res_zero;
`endif

    modport master (
        output req_valid, req_a, req_b, req_op, res_ready,
        input  req_ready, res_valid, res_data
`ifdef ALU_DRV_ZERO_FLAG_EN
        , input res_zero
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, res_ready,
        output req_ready, res_valid, res_data
`ifdef ALU_DRV_ZERO_FLAG_EN
        , output res_zero
`endif
    );
endinterface

// File: rtl/alu_operand_driver.sv
// Registers ALU operands on request, waits SETTLE cycles, captures and returns the ALU result.
// Optional zero flag on the result port via ALU_DRV_ZERO_FLAG_EN.
module alu_operand_driver
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = alu_pkg::WIDTH,
    parameter int unsigned OPW    = alu_pkg::OPW,
    parameter int unsigned SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_operand_driver_if.slave    bus,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [OPW-1:0]         alu_op,
    input  logic [WIDTH-1:0]       alu_s,
    output logic [15:0]            res_count,
    output logic                   busy
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("alu_operand_driver: SETTLE must be in 1..15");
    end

    drv_state_t       state;
    logic [3:0]       cnt;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             accept;

    assign bus.req_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.res_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data;
    assign busy          = (state != ST_IDLE);

`ifdef ALU_DRV_ZERO_FLAG_EN
    logic res_zero;
    assign bus.res_zero = res_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_zero <= 1'b0;
        end else if (state == ST_SETTLE && cnt == '0) begin
            res_zero <= (alu_s == '0);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_count <= '0;
        end else begin
            // Accept can happen in IDLE or in DONE alongside the result handshake.
            if (accept) begin
                alu_a  <= bus.req_a;
                alu_b  <= bus.req_b;
                alu_op <= bus.req_op;
                cnt    <= 4'(SETTLE - 1);
            end
            case (state)
                ST_IDLE: begin
                    if (accept) state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        res_data  <= alu_s;
                        res_valid <= 1'b1;
                        res_count <= res_count + 16'd1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        state     <= accept ? ST_SETTLE : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_driver.sv
// Directed-vector bench for alu_operand_driver with a behavioural ALU on the far side.
// Define ALU_DRV_ZERO_FLAG_EN to also exercise the zero flag.
module tb_alu_operand_driver;
    import alu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       alu_a, alu_b, alu_s;
    logic [2:0]        alu_op;
    logic [15:0]       res_count;
    logic              busy;
    int                vectors = 0;
    int                miscompares = 0;
    int                cyc = 0;

    alu_operand_driver_if #(.WIDTH(32), .OPW(3)) bus ();

    alu_operand_driver #(.WIDTH(32), .OPW(3), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s),
        .res_count(res_count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        alu_s = '0;
        case (alu_op)
            ALU_AND: alu_s = alu_a & alu_b;
            ALU_OR:  alu_s = alu_a | alu_b;
            ALU_ADD: alu_s = alu_a + alu_b;
            ALU_SUB: alu_s = alu_a - alu_b;
            ALU_SLT: alu_s = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_s = '0;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents a request just after a rising edge; it is accepted on the next edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.req_valid = 1'b1;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_op = op;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, output int edges, output int at_cyc);
        edges = 0;
        at_cyc = 0;
        while (edges < 20) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.res_valid) begin
                at_cyc = cyc;
                return;
            end
        end
        check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    int lat, t1, t2;
    logic [31:0] held_data, held_a;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        bus.res_ready = 1'b1;
        #12;
        check_val("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check_val("rst_res_data", bus.res_data, 32'd0);
        check_val("rst_res_count", {16'd0, res_count}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_alu_a", alu_a, 32'd0);
        check_val("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset mid-SETTLE discards the request
        send(32'h1234_5678, 32'h1, ALU_ADD);
        check_val("midrst_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_alu_a", alu_a, 32'd0);
        check_val("midrst_alu_op", {29'd0, alu_op}, 32'd0);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_val("midrst_no_valid", {31'd0, bus.res_valid}, 32'd0);
        check_val("midrst_count", {16'd0, res_count}, 32'd0);

        // AND with latency check, then backpressure
        bus.res_ready = 1'b0;
        send(32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND);
        wait_result("and", lat, t1);
        check_val("and_latency", lat, 32'd2);
        check_val("and_data", bus.res_data, 32'hF000_F000);
        check_val("and_count", {16'd0, res_count}, 32'd1);
        held_data = bus.res_data;
        held_a = alu_a;
        bus.req_valid = 1'b1;
        bus.req_a = 32'hDEAD_BEEF;
        bus.req_b = 32'h0;
        bus.req_op = ALU_OR;
        repeat (10) begin
            @(negedge clk);
            check_val("bp_valid", {31'd0, bus.res_valid}, 32'd1);
            check_val("bp_data", bus.res_data, held_data);
            check_val("bp_alu_a", alu_a, held_a);
            check_val("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_release_valid", {31'd0, bus.res_valid}, 32'd0);
        check_val("bp_release_busy", {31'd0, busy}, 32'd0);
        check_val("bp_count", {16'd0, res_count}, 32'd1);

        // Back-to-back ADD then SUB
        bus.req_valid = 1'b1;
        bus.req_a = 32'd1;
        bus.req_b = 32'd2;
        bus.req_op = ALU_ADD;
        @(posedge clk);
        #1;
        bus.req_a = 32'd5;
        bus.req_b = 32'd7;
        bus.req_op = ALU_SUB;
        wait_result("b2b_add", lat, t1);
        check_val("b2b_add_data", bus.res_data, 32'h0000_0003);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check_val("b2b_alu_op", {29'd0, alu_op}, {29'd0, ALU_SUB});
        wait_result("b2b_sub", lat, t2);
        check_val("b2b_sub_data", bus.res_data, 32'hFFFF_FFFE);
        check_val("b2b_spacing", t2 - t1, 32'd3);
        check_val("b2b_count", {16'd0, res_count}, 32'd3);
        @(posedge clk);
        #1;

        // SLT signed
        send(32'hFFFF_FFFF, 32'd1, ALU_SLT);
        wait_result("slt", lat, t1);
        check_val("slt_data", bus.res_data, 32'd1);
        @(posedge clk);
        #1;

        // Counter wrap
        force dut.res_count = 16'hFFFF;
        @(posedge clk);
        #1 release dut.res_count;
        check_val("wrap_preload", {16'd0, res_count}, 32'h0000_FFFF);
        send(32'd3, 32'd4, ALU_OR);
        wait_result("wrap", lat, t1);
        check_val("wrap_data", bus.res_data, 32'd7);
        check_val("wrap_count", {16'd0, res_count}, 32'd0);
        @(posedge clk);
        #1;

`ifdef ALU_DRV_ZERO_FLAG_EN
        send(32'd9, 32'd9, ALU_SUB);
        wait_result("zf_sub", lat, t1);
        check_val("zf_sub_data", bus.res_data, 32'd0);
        check_val("zf_sub_zero", {31'd0, bus.res_zero}, 32'd1);
        @(posedge clk);
        #1;
        send(32'd1, 32'd1, ALU_AND);
        wait_result("zf_and", lat, t1);
        check_val("zf_and_data", bus.res_data, 32'd1);
        check_val("zf_and_zero", {31'd0, bus.res_zero}, 32'd0);
        @(posedge clk);
        #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
